mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store memory-port sequencer sitting directly downstream of the multicycle control FSM and its datapath.
//  Takes one load or store request (address, funct3, store data) and drives the word-addressed memory port.
//  Holds the request until mem_resp, then returns aligned, sign-/zero-extended load data and RVFI rmask/wmask.
//  Flags misaligned accesses and illegal funct3 as errors. Offers an optional response timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  0   cycles in ACCESS without mem_resp before abort; 0 = never abort
//  CNT_W           16  width of timeout counter; TIMEOUT_CYCLES < 2**CNT_W
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous reset, active-low (0 = reset, sampled on posedge clk)
//  req_valid        in   1   request strobe from control; sampled only in IDLE
//  req_we           in   1   1 = store, 0 = load
//  req_funct3       in   3   load_funct3_t / store_funct3_t encoding
//  req_addr         in   32  byte address (from MAR)
//  req_wdata        in   32  store data, low-aligned (rs2 value)
//  busy             out  1   state != IDLE
//  resp_valid       out  1   one-cycle pulse: access complete or aborted
//  resp_err         out  1   valid with resp_valid: misaligned, illegal funct3 or timeout
//  resp_rdata       out  32  extended load data; held until next accepted request
//  rmask            out  4   RVFI read mask of last request; held like resp_rdata
//  wmask            out  4   RVFI write mask of last request; held like resp_rdata
//  mem_address      out  32  {addr[31:2],2'b00}
//  mem_read         out  1   high throughout ACCESS for loads
//  mem_write        out  1   high throughout ACCESS for stores
//  mem_byte_enable  out  4   lane mask, stable throughout ACCESS
//  mem_wdata        out  32  req_wdata << 8*addr[1:0]
//  mem_rdata        in   32  read data, valid with mem_resp
//  mem_resp         in   1   memory completion, one cycle
// BEHAVIOUR
//  Reset: state=IDLE, counter=0. All outputs are 0, including resp_rdata, rmask and wmask. Reset mid-ACCESS drops mem_read/mem_write on the next edge.
//  States: IDLE -> ACCESS (legal req) | ERR (illegal req); ACCESS -> DONE (mem_resp) | ERR (timeout); DONE,ERR -> IDLE.
//  Accept (IDLE, req_valid=1): latch we, funct3, addr, wdata. Compute lane mask lm:
//    b/bu: 4'b0001<<off; h/hu: 4'b0011<<off; w: 4'b1111; off = addr[1:0].
//  Illegal: h/hu/sh with off[0]=1; w/sw with off!=0; funct3 not in the enum (loads 3,6,7; stores >=3).
//    No memory access. ERR state: resp_valid=1, resp_err=1, rmask=wmask=0.
//  ACCESS: mem_read = ~we, mem_write = we, be=lm, mem_address and mem_wdata from the latched request.
//    Loads drive be = lm. Memory ignores it; RVFI uses it.
//  On mem_resp in ACCESS: shift mem_rdata >> 8*off, then extend:
//    lb: sext [7:0]; lbu: zext [7:0]; lh: sext [15:0]; lhu: zext [15:0]; lw: all 32 bits.
//    Register the result into resp_rdata. Set rmask=lm for loads, else 0; wmask=lm for stores, else 0. Go to DONE.
//  DONE: resp_valid=1, resp_err=0 for one cycle. Stores leave resp_rdata unchanged.
//  Latency: accept at edge N; mem_read/write high from N+1. mem_resp in cycle N+k (k>=1) gives resp_valid in N+k+1.
//  Timeout (TIMEOUT_CYCLES>0): counter clears on entering ACCESS and increments each ACCESS cycle without mem_resp.
//    When counter reaches TIMEOUT_CYCLES: ERR, and mem_read/write drop on that edge.
//    If mem_resp arrives in the same cycle as the timeout, the response wins and the unit goes to DONE.
//  req_valid outside IDLE is ignored; it is not queued. req_valid is accepted in the IDLE cycle that follows DONE/ERR.
//  mem_resp outside ACCESS is ignored.
// STRUCTURE
//  rv32i_types: add mau_state_t {IDLE,ACCESS,DONE,ERR}; reuse load_funct3_t and store_funct3_t.
//  One combinational sub-module mem_align: (funct3, off, we, wdata, mem_rdata) -> lm, illegal, mem_wdata, ext_rdata.
//  Top holds the FSM, request latch, timeout counter and response registers.
// TESTING
//  1. lw addr=0x100, mem_resp 1 cycle later with rdata=0xDEADBEEF -> mem_address=0x100, resp_rdata=0xDEADBEEF, rmask=1111.
//  2. lb addr=0x103, rdata=0x80FF_0000 -> be=1000, resp_rdata=0xFFFFFF80. lbu at the same address -> 0x00000080.
//  3. sh addr=0x202, wdata=0x0000ABCD -> mem_write=1, be=1100, mem_wdata=0xABCD0000, wmask=1100, mem_address=0x200.
//  4. lw addr=0x101, or sh addr=0x203 -> no mem_read/mem_write, resp_valid=1 with resp_err=1 one cycle after accept.
//  5. TIMEOUT_CYCLES=4, no mem_resp -> mem_read high 4 cycles, then resp_err=1, unit returns to IDLE.
//     Repeat with mem_resp in the 4th cycle -> DONE, resp_err=0.
//  6. rst=0 mid-ACCESS -> next edge: all outputs 0, state IDLE. req_valid held high during ACCESS is not re-accepted.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store memory-port sequencer.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } mau_state_t;

    // Byte lane offset scaled to a bit shift amount.
    function automatic logic [4:0] lane_shift(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed memory port between the sequencer (master) and memory (slave).
//
// Handshake: the master holds mem_read or mem_write high, together with a
// stable mem_address, mem_byte_enable and mem_wdata, for as long as the
// access is outstanding. The slave completes it by pulsing mem_resp for
// exactly one cycle (mem_rdata valid in that cycle for reads). The master
// drops mem_read/mem_write on the edge that samples mem_resp. There is no
// backpressure on the response side.
interface mem_access_unit_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational lane/alignment helper: lane mask, legality, store data
// placement and load data extraction with sign/zero extension.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  lm,
    output logic        illegal,
    output logic [31:0] mem_wdata,
    output logic [31:0] ext_rdata
);

    logic [31:0] shifted;

    // Lane mask and legality from access size and byte offset.
    always_comb begin
        lm      = 4'b0000;
        illegal = 1'b0;
        if (we) begin
            case (funct3)
                SB:      lm = 4'b0001 << off;
                SH:      begin lm = 4'b0011 << off; illegal = off[0]; end
                SW:      begin lm = 4'b1111; illegal = (off != 2'b00); end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB, LBU: lm = 4'b0001 << off;
                LH, LHU: begin lm = 4'b0011 << off; illegal = off[0]; end
                LW:      begin lm = 4'b1111; illegal = (off != 2'b00); end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Place store data into its byte lanes; bring load data down to bit 0.
    always_comb begin
        mem_wdata = wdata << lane_shift(off);
        shifted   = mem_rdata >> lane_shift(off);
    end

    // Extend the selected load field to 32 bits.
    always_comb begin
        ext_rdata = shifted;
        case (funct3)
            LB:      ext_rdata = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     ext_rdata = {24'h000000, shifted[7:0]};
            LH:      ext_rdata = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     ext_rdata = {16'h0000, shifted[15:0]};
            default: ext_rdata = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: accepts one request, drives the memory port until
// mem_resp (or timeout), then reports extended load data and RVFI masks.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                busy,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [31:0]         resp_rdata,
    output logic [3:0]          rmask,
    output logic [3:0]          wmask,
    output mau_state_t          dbg_state,
    mem_access_unit_if.master   mem
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    mau_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        lm_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic [3:0]        rmask_q, wmask_q;

    logic              accept;
    logic              timeout_hit;
    logic [2:0]        al_funct3;
    logic [1:0]        al_off;
    logic              al_we;
    logic [3:0]        al_lm;
    logic              al_illegal;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;

    assign accept      = (state_q == IDLE) && req_valid;
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // While idle the aligner judges the incoming request; afterwards it
    // works on the latched request so load data is extracted correctly.
    always_comb begin
        al_funct3 = funct3_q;
        al_off    = addr_q[1:0];
        al_we     = we_q;
        if (state_q == IDLE) begin
            al_funct3 = req_funct3;
            al_off    = req_addr[1:0];
            al_we     = req_we;
        end
    end

    mem_align u_align (
        .funct3    (al_funct3),
        .off       (al_off),
        .we        (al_we),
        .wdata     (req_wdata),
        .mem_rdata (mem.mem_rdata),
        .lm        (al_lm),
        .illegal   (al_illegal),
        .mem_wdata (al_wdata),
        .ext_rdata (al_rdata)
    );

    // Next-state logic; a response in the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = al_illegal ? ERR : ACCESS;
            ACCESS:  begin
                if (mem.mem_resp)     state_d = DONE;
                else if (timeout_hit) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Request latch, loaded only when a request is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            lm_q     <= 4'b0000;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= al_wdata;
            lm_q     <= al_lm;
        end
    end

    // Timeout counter: held at zero outside ACCESS, counts response-less cycles.
    always_ff @(posedge clk) begin
        if (!rst)                                    cnt_q <= '0;
        else if (state_q != ACCESS)                  cnt_q <= '0;
        else if (!mem.mem_resp)                      cnt_q <= cnt_q + CNT_W'(1);
    end

    // Response registers: updated on completion, masks cleared on error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'h0;
            rmask_q <= 4'b0000;
            wmask_q <= 4'b0000;
        end else if ((state_q == ACCESS) && mem.mem_resp) begin
            if (!we_q) rdata_q <= al_rdata;
            rmask_q <= we_q ? 4'b0000 : lm_q;
            wmask_q <= we_q ? lm_q : 4'b0000;
        end else if (state_d == ERR) begin
            rmask_q <= 4'b0000;
            wmask_q <= 4'b0000;
        end
    end

    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE) || (state_q == ERR);
    assign resp_err   = (state_q == ERR);
    assign resp_rdata = rdata_q;
    assign rmask      = rmask_q;
    assign wmask      = wmask_q;
    assign dbg_state  = state_q;

    assign mem.mem_address     = {addr_q[31:2], 2'b00};
    assign mem.mem_read        = (state_q == ACCESS) && !we_q;
    assign mem.mem_write       = (state_q == ACCESS) && we_q;
    assign mem.mem_byte_enable = lm_q;
    assign mem.mem_wdata       = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomised bench for mem_access_unit with a response scoreboard.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    mau_state_t  dbg_state;

    mem_access_unit_if mem_bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .rmask      (rmask),
        .wmask      (wmask),
        .dbg_state  (dbg_state),
        .mem        (mem_bus)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    // {chk_rdata, err, rdata[31:0], rmask[3:0], wmask[3:0]}
    logic [41:0] exp_q[$];
    logic [31:0] last_rdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic chk_rd, input logic err, input logic [31:0] rd,
                            input logic [3:0] rm, input logic [3:0] wm);
        exp_q.push_back({chk_rd, err, rd, rm, wm});
    endtask

    // Present a request for one cycle; returns at the negedge after acceptance.
    task automatic send_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic mem_pulse(input logic [31:0] rd);
        mem_bus.mem_rdata = rd;
        mem_bus.mem_resp  = 1'b1;
        @(negedge clk);
        mem_bus.mem_resp  = 1'b0;
    endtask

    // Wait (bounded) for resp_valid, compare against the scoreboard head.
    task automatic wait_resp(input string tag, input int budget);
        logic [41:0] e;
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            if (resp_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "_err"}, 32'(resp_err), 32'(e[40]));
                if (e[41]) check({tag, "_rdata"}, resp_rdata, e[39:8]);
                check({tag, "_rmask"}, 32'(rmask), 32'(e[7:4]));
                check({tag, "_wmask"}, 32'(wmask), 32'(e[3:0]));
            end
            check({tag, "_port_quiet"}, 32'({mem_bus.mem_read, mem_bus.mem_write}), 32'd0);
            @(negedge clk);
            check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
            check({tag, "_idle"}, 32'(busy), 32'd0);
        end
    endtask

    // Legal access with mem_resp in the k-th ACCESS cycle.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int k,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        send_req(we, f3, addr, wdata);
        for (int i = 0; i < k; i++) begin
            if (i != 0) @(negedge clk);
            check({tag, "_mem_read"}, 32'(mem_bus.mem_read), 32'(!we));
            check({tag, "_mem_write"}, 32'(mem_bus.mem_write), 32'(we));
            check({tag, "_addr"}, mem_bus.mem_address, {addr[31:2], 2'b00});
            check({tag, "_be"}, 32'(mem_bus.mem_byte_enable), 32'(exp_be));
            if (we) check({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
        end
        mem_pulse(rd);
        wait_resp(tag, 1);
    endtask

    task automatic err_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        push_exp(1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000);
        send_req(we, f3, addr, 32'hFFFF_FFFF);
        check({tag, "_no_access"}, 32'({mem_bus.mem_read, mem_bus.mem_write}), 32'd0);
        wait_resp(tag, 1);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << off;
            3'b001, 3'b101: return off[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    initial begin
        logic [2:0]  f3_tab [5];
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] addr, rd, ev;
        int          k;

        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // Reset, with a request present that must be ignored.
        rst               = 1'b0;
        req_valid         = 1'b1;
        req_we            = 1'b0;
        req_funct3        = 3'b010;
        req_addr          = 32'h0000_0100;
        req_wdata         = 32'h0;
        mem_bus.mem_rdata = 32'h0;
        mem_bus.mem_resp  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp", 32'({resp_valid, resp_err}), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_masks", 32'({rmask, wmask}), 32'd0);
        check("rst_port", 32'({mem_bus.mem_read, mem_bus.mem_write, mem_bus.mem_byte_enable}), 32'd0);
        check("rst_addr", mem_bus.mem_address, 32'h0);
        check("rst_wdata", mem_bus.mem_wdata, 32'h0);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Loads.
        push_exp(1'b1, 1'b0, 32'hDEAD_BEEF, 4'b1111, 4'b0000);
        access("lw", 1'b0, LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0);
        push_exp(1'b1, 1'b0, 32'hFFFF_FF80, 4'b1000, 4'b0000);
        access("lb", 1'b0, LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 4'b1000, 32'h0);
        push_exp(1'b1, 1'b0, 32'h0000_0080, 4'b1000, 4'b0000);
        access("lbu", 1'b0, LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 4'b1000, 32'h0);
        push_exp(1'b1, 1'b0, 32'hFFFF_8001, 4'b1100, 4'b0000);
        access("lh", 1'b0, LH, 32'h0000_0102, 32'h0, 32'h8001_1234, 3, 4'b1100, 32'h0);
        push_exp(1'b1, 1'b0, 32'h0000_8001, 4'b1100, 4'b0000);
        access("lhu", 1'b0, LHU, 32'h0000_0102, 32'h0, 32'h8001_1234, 1, 4'b1100, 32'h0);
        last_rdata = 32'h0000_8001;

        // Stores leave the load data register untouched.
        push_exp(1'b1, 1'b0, last_rdata, 4'b0000, 4'b1100);
        access("sh", 1'b1, SH, 32'h0000_0202, 32'h0000_ABCD, 32'h5555_5555, 1, 4'b1100, 32'hABCD_0000);
        push_exp(1'b1, 1'b0, last_rdata, 4'b0000, 4'b0010);
        access("sb", 1'b1, SB, 32'h0000_0201, 32'h1234_5677, 32'h0, 1, 4'b0010, 32'h3456_7700);
        push_exp(1'b1, 1'b0, last_rdata, 4'b0000, 4'b1111);
        access("sw", 1'b1, SW, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 2, 4'b1111, 32'hCAFE_F00D);

        // Misaligned and illegal funct3.
        err_req("lw_mis", 1'b0, LW, 32'h0000_0101);
        err_req("sh_mis", 1'b1, SH, 32'h0000_0203);
        err_req("lh_mis", 1'b0, LH, 32'h0000_0101);
        err_req("sw_mis", 1'b1, SW, 32'h0000_0202);
        err_req("ld_f3_3", 1'b0, 3'd3, 32'h0000_0100);
        err_req("st_f3_4", 1'b1, 3'd4, 32'h0000_0100);

        // Timeout: four ACCESS cycles, then error.
        push_exp(1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000);
        send_req(1'b0, LW, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_mem_read", 32'(mem_bus.mem_read), 32'd1);
            @(negedge clk);
        end
        wait_resp("to_abort", 1);
        // Response in the fourth cycle beats the timeout.
        push_exp(1'b1, 1'b0, 32'h0BAD_F00D, 4'b1111, 4'b0000);
        access("to_resp", 1'b0, LW, 32'h0000_0304, 32'h0, 32'h0BAD_F00D, 4, 4'b1111, 32'h0);
        last_rdata = 32'h0BAD_F00D;

        // Reset in the middle of ACCESS with req_valid held.
        req_we     = 1'b0;
        req_funct3 = LW;
        req_addr   = 32'h0000_0400;
        req_valid  = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("mid_mem_read", 32'(mem_bus.mem_read), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        check("mid_rst_port", 32'({mem_bus.mem_read, mem_bus.mem_write, mem_bus.mem_byte_enable}), 32'd0);
        check("mid_rst_addr", mem_bus.mem_address, 32'h0);
        check("mid_rst_resp", 32'({resp_valid, resp_err, rmask, wmask}), 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'h0);
        req_valid = 1'b0;
        rst       = 1'b1;
        exp_q.delete();
        last_rdata = 32'h0;
        @(negedge clk);

        // req_valid kept high during ACCESS with new fields is not taken.
        push_exp(1'b1, 1'b0, 32'h1122_3344, 4'b1111, 4'b0000);
        req_funct3 = LW;
        req_addr   = 32'h0000_0500;
        req_valid  = 1'b1;
        @(negedge clk);
        req_funct3 = LB;
        req_addr   = 32'h0000_0607;
        @(negedge clk);
        check("hold_addr", mem_bus.mem_address, 32'h0000_0500);
        check("hold_be", 32'(mem_bus.mem_byte_enable), 32'h0000_000F);
        req_valid = 1'b0;
        mem_pulse(32'h1122_3344);
        wait_resp("hold", 1);
        last_rdata = 32'h1122_3344;

        // mem_resp while idle has no effect.
        mem_pulse(32'hFFFF_FFFF);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("idle_rdata", resp_rdata, last_rdata);

        // Random legal loads with variable response latency.
        for (int i = 0; i < 10; i++) begin
            f3 = f3_tab[$urandom_range(0, 4)];
            case (f3)
                3'b000, 3'b100: off = 2'($urandom_range(0, 3));
                3'b001, 3'b101: off = 2'($urandom_range(0, 1) * 2);
                default:        off = 2'd0;
            endcase
            addr = ($urandom() & 32'hFFFF_FFFC) | {30'h0, off};
            rd   = $urandom();
            k    = $urandom_range(1, 3);
            ev   = model_load(f3, off, rd);
            push_exp(1'b1, 1'b0, ev, model_mask(f3, off), 4'b0000);
            access("rnd_ld", 1'b0, f3, addr, 32'h0, rd, k, model_mask(f3, off), 32'h0);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
